rst_sequencer: RTL

- Central reset controller for a board-level clock/reset block.
- Drives the asynchronous reset and the deassert input of NUM_DOMAINS downstream per-domain reset synchronizers.
- Releases the domains strictly in index order. Each domain is released only after the previous domain's synchronized reset is seen low.
- Re-asserts every domain on PLL lock loss, a software reset request, or an acknowledge timeout.

---
 rtl/rst_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - central reset controller releasing downstream domains in index order
module rst_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int ACK_TIMEOUT = 1024,
    parameter int SYNC_STAGES = 2,
    localparam int CUR_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_async,
    input  logic                   pll_locked,
    input  logic                   sw_rst_req,
    input  logic [NUM_DOMAINS-1:0] dom_rst_ack,
    output logic [NUM_DOMAINS-1:0] dom_rst_async,
    output logic [NUM_DOMAINS-1:0] dom_deassert,
    output logic [CUR_W-1:0]       cur_domain,
    output logic                   sys_ready,
    output logic                   timeout_err
);
    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam int ACK_W  = $clog2(ACK_TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [CUR_W-1:0]  CUR_LAST  = CUR_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        ST_ASSERT    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0]                  lock_sync_q, lock_sync_d;
    logic [SYNC_STAGES-1:0][NUM_DOMAINS-1:0] ack_sync_q, ack_sync_d;
    logic                                    lock_s;
    logic [NUM_DOMAINS-1:0]                  ack_s;

    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [ACK_W-1:0]       ack_cnt_q, ack_cnt_d;
    logic [CUR_W-1:0]       cur_domain_q, cur_domain_d;
    logic [NUM_DOMAINS-1:0] dom_rst_async_q, dom_rst_async_d;
    logic [NUM_DOMAINS-1:0] dom_deassert_q, dom_deassert_d;
    logic                   sys_ready_q, sys_ready_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   enter_assert;

    // Acks reset high so a domain never looks released before it really is.
    always_comb begin
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
        ack_sync_d  = {ack_sync_q[SYNC_STAGES-2:0], dom_rst_ack};
        lock_s      = lock_sync_q[SYNC_STAGES-1];
        ack_s       = ack_sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        ack_cnt_d       = ack_cnt_q;
        cur_domain_d    = cur_domain_q;
        dom_rst_async_d = dom_rst_async_q;
        dom_deassert_d  = dom_deassert_q;
        sys_ready_d     = sys_ready_q;
        timeout_err_d   = timeout_err_q;
        enter_assert    = 1'b0;

        case (state_q)
            ST_ASSERT: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d         = ST_WAIT_LOCK;
                    dom_rst_async_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d        = ST_RELEASE;
                    cur_domain_d   = '0;
                    dom_deassert_d = NUM_DOMAINS'(1);
                    ack_cnt_d      = '0;
                end
            end
            ST_RELEASE: begin
                if (!lock_s || sw_rst_req) begin
                    enter_assert = 1'b1;
                end else if (!ack_s[cur_domain_q]) begin
                    if (cur_domain_q == CUR_LAST) begin
                        state_d     = ST_RUN;
                        sys_ready_d = 1'b1;
                    end else begin
                        // Shifting a one in keeps the released set contiguous from bit 0.
                        cur_domain_d   = cur_domain_q + CUR_W'(1);
                        dom_deassert_d = {dom_deassert_q[NUM_DOMAINS-2:0], 1'b1};
                        ack_cnt_d      = '0;
                    end
                end else if (ack_cnt_q == ACK_LAST) begin
                    timeout_err_d = 1'b1;
                    enter_assert  = 1'b1;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_W'(1);
                end
            end
            ST_RUN: begin
                if (sw_rst_req || !lock_s) begin
                    enter_assert = 1'b1;
                end
            end
            default: begin
                enter_assert = 1'b1;
            end
        endcase

        if (enter_assert) begin
            state_d         = ST_ASSERT;
            dom_rst_async_d = '1;
            dom_deassert_d  = '0;
            sys_ready_d     = 1'b0;
            cur_domain_d    = '0;
            hold_cnt_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q         <= ST_ASSERT;
            lock_sync_q     <= '0;
            ack_sync_q      <= '1;
            hold_cnt_q      <= '0;
            ack_cnt_q       <= '0;
            cur_domain_q    <= '0;
            dom_rst_async_q <= '1;
            dom_deassert_q  <= '0;
            sys_ready_q     <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            lock_sync_q     <= lock_sync_d;
            ack_sync_q      <= ack_sync_d;
            hold_cnt_q      <= hold_cnt_d;
            ack_cnt_q       <= ack_cnt_d;
            cur_domain_q    <= cur_domain_d;
            dom_rst_async_q <= dom_rst_async_d;
            dom_deassert_q  <= dom_deassert_d;
            sys_ready_q     <= sys_ready_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign dom_rst_async = dom_rst_async_q;
    assign dom_deassert  = dom_deassert_q;
    assign cur_domain    = cur_domain_q;
    assign sys_ready     = sys_ready_q;
    assign timeout_err   = timeout_err_q;

endmodule
